// File: rtl/clk_mgr_pkg.sv
// Clock-domain manager shared types and constants.
// Imported by the manager top and its helpers.
`timescale 1ns/1ps
package clk_mgr_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } mgr_state_t;

  localparam int DEF_NUM_CEN     = 2;
  localparam int DEF_ACC_W       = 16;
  localparam int DEF_LOCK_STABLE = 1024;
  localparam int DEF_CNT_W       = 8;

  // Phase increment for a target strobe rate, rounded to nearest.
  function automatic longint calc_inc(
    input real f_out,
    input real f_clk,
    input int  acc_w
  );
    real scaled;
    scaled = f_out * (2.0 ** acc_w) / f_clk;
    return longint'(scaled);
  endfunction

endpackage

// File: rtl/clk_domain_manager_cen.sv
// Fractional clock-enable generator (phase accumulator).
// Carry out of the wrapping add is registered as the strobe.
`timescale 1ns/1ps
module frac_cen_gen #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [ACC_W-1:0] inc,
  output logic             cen
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, inc};

  // Accumulate while enabled; otherwise hold phase and strobe at zero.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      acc <= '0;
      cen <= 1'b0;
    end else begin
      acc <= sum[ACC_W-1:0];
      cen <= sum[ACC_W];
    end
  end

endmodule

// File: rtl/clk_domain_manager.sv
// PLL lock qualification, system reset and clock-enable strobes.
// sys_rst is decoded from the state register only.
`timescale 1ns/1ps
module clk_domain_manager
  import clk_mgr_pkg::*;
#(
  parameter int NUM_CEN            = DEF_NUM_CEN,
  parameter int ACC_W              = DEF_ACC_W,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE,
  parameter int CNT_W              = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pll_locked,
  input  logic [NUM_CEN*ACC_W-1:0] cen_inc,
  output logic                     sys_rst,
  output logic                     ready,
  output logic [NUM_CEN-1:0]       cen,
  output logic [CNT_W-1:0]         lock_loss_count,
  output logic [1:0]               mgr_state
);

  localparam int SC_W = $clog2(LOCK_STABLE_CYCLES);
  localparam logic [SC_W-1:0] LAST = SC_W'(LOCK_STABLE_CYCLES - 1);

  mgr_state_t       state, state_n;
  logic             sync1, locked_s;
  logic [SC_W-1:0]  cnt, cnt_n;
  logic [CNT_W-1:0] llc, llc_n;
  logic             run_hold;

  // Synchroniser, state, window counter and loss counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
      state    <= WAIT_LOCK;
      cnt      <= '0;
      llc      <= '0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
      state    <= state_n;
      cnt      <= cnt_n;
      llc      <= llc_n;
    end
  end

  // Next-state logic; any glitch in STABLE restarts the window.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    llc_n   = llc;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
        end else if (cnt == LAST) begin
          state_n = RUN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          if (llc != {CNT_W{1'b1}}) begin
            llc_n = llc + 1'b1;
          end
        end
      end
      default: state_n = WAIT_LOCK;
    endcase
  end

  // Accumulators run only while staying in RUN, so the leaving edge clears them.
  assign run_hold = (state == RUN) && (state_n == RUN);

  assign sys_rst         = (state != RUN);
  assign ready           = ~sys_rst;
  assign lock_loss_count = llc;
  assign mgr_state       = state;

  for (genvar i = 0; i < NUM_CEN; i++) begin : g_cen
    frac_cen_gen #(
      .ACC_W (ACC_W)
    ) u_cen (
      .clk    (clk),
      .rst    (rst),
      .enable (run_hold),
      .inc    (cen_inc[i*ACC_W +: ACC_W]),
      .cen    (cen[i])
    );
  end

endmodule

// File: tb/tb_clk_domain_manager.sv
// Self-checking bench for clk_domain_manager.
// Vector table for bring-up, directed sequences for corners.
`timescale 1ns/1ps
module tb_clk_domain_manager;

  logic        clk;
  logic        rst;
  logic        pll_locked;
  logic [31:0] cen_inc;
  logic        sys_rst;
  logic        ready;
  logic [1:0]  cen;
  logic [1:0]  lock_loss_count;
  logic [1:0]  mgr_state;

  int n_chk;
  int n_fail;

  clk_domain_manager #(
    .NUM_CEN            (2),
    .ACC_W              (16),
    .LOCK_STABLE_CYCLES (16),
    .CNT_W              (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .cen_inc         (cen_inc),
    .sys_rst         (sys_rst),
    .ready           (ready),
    .cen             (cen),
    .lock_loss_count (lock_loss_count),
    .mgr_state       (mgr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         steps;
    logic       rst_v;
    logic       pll_v;
    logic [1:0] st;
    logic       sr;
    logic       rdy;
    logic [1:0] cen_e;
    logic [1:0] llc_e;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input vec_t v);
    chk({nm, ".state"}, 32'(mgr_state), 32'(v.st));
    chk({nm, ".sys_rst"}, 32'(sys_rst), 32'(v.sr));
    chk({nm, ".ready"}, 32'(ready), 32'(v.rdy));
    chk({nm, ".cen"}, 32'(cen), 32'(v.cen_e));
    chk({nm, ".llc"}, 32'(lock_loss_count), 32'(v.llc_e));
  endtask

  initial begin
    int cnt0;
    int cnt1;
    int exp_llc;
    logic e0;
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{"reset",   4, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 2'b00, 2'd0};
    vecs[1] = '{"sync",    2, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'b00, 2'd0};
    vecs[2] = '{"stable",  1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'b00, 2'd0};
    vecs[3] = '{"window", 15, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'b00, 2'd0};
    vecs[4] = '{"run",     1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'b00, 2'd0};
    vecs[5] = '{"cen_c5",  4, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'b01, 2'd0};
    vecs[6] = '{"drop_d1", 2, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 2'b10, 2'd0};
    vecs[7] = '{"drop_d2", 1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'b00, 2'd1};

    rst        = 1'b1;
    pll_locked = 1'b1;
    cen_inc    = {16'h5556, 16'h4000};

    for (int i = 0; i < 8; i++) begin
      rst        = vecs[i].rst_v;
      pll_locked = vecs[i].pll_v;
      repeat (vecs[i].steps) step();
      chk_all(vecs[i].name, vecs[i]);
    end

    // Glitch in STABLE at counter=10 restarts the full window.
    pll_locked = 1'b1;
    repeat (13) step();
    chk("glitch.pre_state", 32'(mgr_state), 32'd1);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    repeat (2) step();
    chk("glitch.state", 32'(mgr_state), 32'd0);
    chk("glitch.sys_rst", 32'(sys_rst), 32'd1);
    repeat (16) step();
    chk("glitch.hold", 32'(sys_rst), 32'd1);
    step();
    chk("glitch.release", 32'(sys_rst), 32'd0);
    chk("glitch.run", 32'(mgr_state), 32'd2);
    chk("glitch.llc", 32'(lock_loss_count), 32'd1);

    // Fresh RUN cycle 1: cen[0] period 4 from cycle 5, cen[1] about 1/3.
    cnt1 = 0;
    for (int c = 1; c <= 3000; c++) begin
      if (c <= 40) begin
        e0 = (c >= 5) && (((c - 5) % 4) == 0);
        chk("cen0_phase", 32'(cen[0]), 32'(e0));
      end
      cnt1 += int'(cen[1]);
      step();
    end
    chk("cen1_rate", 32'((cnt1 >= 999) && (cnt1 <= 1001)), 32'd1);

    // Repeated losses saturate the 2-bit counter at 3.
    for (int k = 2; k <= 5; k++) begin
      exp_llc    = (k > 3) ? 3 : k;
      pll_locked = 1'b0;
      repeat (3) step();
      chk("loss.sys_rst", 32'(sys_rst), 32'd1);
      chk("loss.cen", 32'(cen), 32'd0);
      chk("loss.llc", 32'(lock_loss_count), 32'(exp_llc));
      pll_locked = 1'b1;
      repeat (19) step();
      chk("loss.rerun", 32'(mgr_state), 32'd2);
    end

    // Boundary increments: 0 never strobes, 0xFFFF strobes almost always.
    pll_locked = 1'b0;
    repeat (3) step();
    chk("sat.llc", 32'(lock_loss_count), 32'd3);
    cen_inc    = {16'hFFFF, 16'h0000};
    pll_locked = 1'b1;
    repeat (19) step();
    chk("bnd.run", 32'(mgr_state), 32'd2);
    cnt0 = 0;
    cnt1 = 0;
    for (int c = 1; c <= 1002; c++) begin
      cnt0 += int'(cen[0]);
      if (c <= 2) chk("bnd.ffff_first", 32'(cen[1]), 32'd0);
      else cnt1 += int'(cen[1]);
      step();
    end
    chk("bnd.zero_inc", 32'(cnt0), 32'd0);
    chk("bnd.ffff_inc", 32'(cnt1), 32'd1000);

    // Reset mid-RUN clears everything, then re-qualifies from scratch.
    cen_inc = {16'h5556, 16'h4000};
    rst     = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst.state", 32'(mgr_state), 32'd0);
    chk("mrst.sys_rst", 32'(sys_rst), 32'd1);
    chk("mrst.ready", 32'(ready), 32'd0);
    chk("mrst.cen", 32'(cen), 32'd0);
    chk("mrst.llc", 32'(lock_loss_count), 32'd0);
    repeat (18) step();
    chk("mrst.hold", 32'(sys_rst), 32'd1);
    step();
    chk("mrst.release", 32'(sys_rst), 32'd0);
    chk("mrst.run", 32'(mgr_state), 32'd2);
    repeat (3) step();
    chk("mrst.cen_c4", 32'(cen), 32'b10);
    step();
    chk("mrst.cen_c5", 32'(cen), 32'b01);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_domain_manager.md
Name: clk_domain_manager

Overview:
- Sits directly behind the Tang9K rPLL wrapper, in the generated 72 MHz domain.
- Synchronises the PLL lock, qualifies it over a stable window and generates the synchronous system reset.
- Tracks lock-loss events.
- Provides NUM_CEN parametrised fractional clock-enable strobes (phase-accumulator based) so UART, PWM and timer blocks run from one clock instead of extra PLL outputs.

Parameters:
- NUM_CEN, 2, number of independent clock-enable channels (1..8).
- ACC_W, 16, phase-accumulator width per channel (8..32).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before reset release (>=2).
- CNT_W, 8, width of the saturating lock-loss counter.

Ports:
- clk  in  1  system clock (PLL output).
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  raw PLL LOCK, asynchronous to clk.
- cen_inc  in  NUM_CEN*ACC_W  per-channel phase increment; channel i is bits [i*ACC_W +: ACC_W]; quasi-static.
- sys_rst  out  1  synchronous active-high reset for downstream logic.
- ready  out  1  equals ~sys_rst.
- cen  out  NUM_CEN  single-cycle enable strobes.
- lock_loss_count  out  CNT_W  saturating count of RUN->WAIT_LOCK transitions.
- mgr_state  out  2  debug: current FSM state encoding.

Behaviour:
- Reset values (rst=1, synchronous): state=WAIT_LOCK, sync flops=0, stable counter=0, sys_rst=1, ready=0, cen=0, all accumulators=0, lock_loss_count=0.
- Lock synchroniser: 2-flop chain; locked_s is the second stage.
- FSM states: WAIT_LOCK=0, STABLE=1, RUN=2; encoding 3 is illegal and recovers to WAIT_LOCK next cycle.
  - WAIT_LOCK: locked_s=1 -> STABLE, with counter cleared to 0.
  - STABLE: locked_s=0 -> WAIT_LOCK. Otherwise the counter increments; when counter==LOCK_STABLE_CYCLES-1 and locked_s=1 -> RUN.
  - RUN: locked_s=0 -> WAIT_LOCK, and lock_loss_count increments, saturating at 2^CNT_W-1.
- Reset output:
  - sys_rst = (state != RUN), driven from the state register only, so it is glitch-free.
  - Latency: pll_locked high sampled at edge E0 -> sys_rst low after edge E(LOCK_STABLE_CYCLES+2).
  - Lock drop sampled at E0 -> sys_rst high after E2.
- Lock glitch in STABLE: any single-cycle drop of locked_s restarts the full stable window.
- Clock-enable channel i, in RUN:
  - Each cycle, {carry, acc_i} = acc_i + inc_i, computed at ACC_W+1 bits; acc_i takes the low ACC_W bits.
  - cen[i] is carry, registered, so it is visible the cycle after the wrapping add.
  - Strobe rate = f_clk*inc_i/2^ACC_W.
  - inc_i=0 -> cen[i] never asserts.
  - Maximum strobe rate is just under every cycle; wrap is modular, with no saturation.
- Outside RUN, accumulators are held at 0 and cen=0. Leaving RUN clears accumulators on the same edge the state changes.
- cen_inc changes take effect on the next add, with no glitch handling; callers change it only while the channel is idle or accept one irregular period.
- rst asserted mid-RUN: all state returns to reset values on the next edge, including lock_loss_count.

Decomposition:
- Package clk_mgr_pkg: mgr_state_t enum {WAIT_LOCK, STABLE, RUN}, default parameter constants, and a function computing the increment for a target frequency, INC = round(f_out*2^ACC_W/f_clk), for constant use.
- Sub-module frac_cen_gen (ports: clk, rst, enable, inc[ACC_W], cen), instantiated NUM_CEN times in a generate loop.
- Synchroniser and FSM live in the top module.

Test Plan:
- Power-up: rst 4 cycles, pll_locked=1 from cycle 0, LOCK_STABLE_CYCLES=16 -> sys_rst=1 through edge E17, sys_rst=0 and ready=1 after E18; mgr_state sequence 0,1,2.
- Glitch in STABLE: LOCK_STABLE_CYCLES=16; drop pll_locked for 1 cycle at counter=10 -> FSM returns to WAIT_LOCK; sys_rst stays 1; release is 18 edges after pll_locked returns; lock_loss_count stays 0.
- Lock loss in RUN: drop pll_locked -> sys_rst=1 two edges later; cen all 0; lock_loss_count 0->1. With CNT_W=2, 5 losses -> count saturates at 3.
- Fractional CEN: ACC_W=16, inc0=0x4000, inc1=0x5556 -> cen[0] first high in RUN cycle 5, then every 4 cycles; cen[1] shows 3 pulses per 9 cycles (average 1/3) over 3000 cycles, within ±1 pulse.
- Boundaries: inc=0 -> no cen over 1000 cycles; inc=0xFFFF -> cen high on 65535 of every 65536 cycles after the first.
- Reset mid-RUN: assert rst for 1 cycle -> next edge sys_rst=1, cen=0, accumulators=0, lock_loss_count=0, mgr_state=0; re-qualification then proceeds as in the power-up scenario.
